rmii_rx_framer: RTL and testbench

//   RMII receive front end. Samples crs_dv/rxd, strips preamble and SFD, and emits
//   the frame body as a dibit stream (out/outclk/done_out) that feeds dibits_to_bytes.

---
 rtl/rmii_rx_framer_pkg.sv | 29 ++
 rtl/rmii_rx_framer_delay.sv | 33 +++
 rtl/rmii_rx_framer.sv | 120 ++++++++++++
 tb/tb_rmii_rx_framer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rmii_rx_framer_pkg.sv
// Shared constants and types for the RMII receive framer: line dibit codes,
// frame size limits and FSM state encodings.
package rmii_rx_framer_pkg;

  typedef logic [1:0] dibit_t;

  typedef struct packed {
    logic   crs_dv;
    dibit_t rxd;
  } rmii_sample_t;

  localparam dibit_t RMII_IDLE_DIBIT = 2'b00;
  localparam dibit_t RMII_PRE_DIBIT  = 2'b01;
  localparam dibit_t RMII_SFD_DIBIT  = 2'b11;

  localparam int RMII_MIN_PREAMBLE_DIBITS = 8;
  localparam int RMII_MAX_FRAME_DIBITS    = 6088;

  localparam logic [1:0] RMII_RX_IDLE = 2'd0;
  localparam logic [1:0] RMII_RX_PRE  = 2'd1;
  localparam logic [1:0] RMII_RX_DATA = 2'd2;
  localparam logic [1:0] RMII_RX_DROP = 2'd3;

  // A body is only a whole number of bytes when the dibit count is a multiple of 4.
  function automatic logic dibits_misaligned(input logic [1:0] cnt_lsbs);
    return cnt_lsbs != 2'b00;
  endfunction

endpackage

// File: rtl/rmii_rx_framer_delay.sv
// Fixed-depth register pipeline with synchronous reset; used to retime the
// raw RMII pins before any decision logic looks at them.
module rmii_rx_framer_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] q_reg;
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (reset) q_reg <= '0;
          else       q_reg <= din;
        end
      end else begin : g_next
        always_ff @(posedge clk) begin
          if (reset) q_reg <= '0;
          else       q_reg <= g_stage[gi-1].q_reg;
        end
      end
    end
  endgenerate

  assign dout = g_stage[DEPTH-1].q_reg;

endmodule

// File: rtl/rmii_rx_framer.sv
// RMII receive front end: strips preamble/SFD, emits the frame body as a
// dibit stream and flags misaligned or oversize frames at end of frame.
module rmii_rx_framer
  import rmii_rx_framer_pkg::*;
#(
  parameter int MIN_PREAMBLE_DIBITS = RMII_MIN_PREAMBLE_DIBITS,
  parameter int MAX_FRAME_DIBITS    = RMII_MAX_FRAME_DIBITS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       crs_dv,
  input  logic [1:0] rxd,
  output logic [1:0] out,
  output logic       outclk,
  output logic       done_out,
  output logic       frame_err
);

  localparam int PRE_W = $clog2(MIN_PREAMBLE_DIBITS + 1);
  localparam int CNT_W = $clog2(MAX_FRAME_DIBITS + 1);

  rmii_sample_t sample_in;
  rmii_sample_t sample_q;
  logic         c1;
  dibit_t       d1;

  assign sample_in = '{crs_dv: crs_dv, rxd: rxd};
  assign c1 = sample_q.crs_dv;
  assign d1 = sample_q.rxd;

  rmii_rx_framer_delay #(
    .WIDTH ($bits(rmii_sample_t)),
    .DEPTH (1)
  ) u_in_reg (
    .clk   (clk),
    .reset (reset),
    .din   (sample_in),
    .dout  (sample_q)
  );

  logic [1:0]       state_reg;
  logic [PRE_W-1:0] pre_cnt_reg;
  logic [CNT_W-1:0] dib_cnt_reg;
  logic             p_val_reg;
  dibit_t           p_dib_reg;
  logic             low_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= RMII_RX_IDLE;
      pre_cnt_reg <= '0;
      dib_cnt_reg <= '0;
      p_val_reg   <= 1'b0;
      p_dib_reg   <= RMII_IDLE_DIBIT;
      low_reg     <= 1'b0;
      out         <= 2'b00;
      outclk      <= 1'b0;
      done_out    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      outclk    <= 1'b0;
      done_out  <= 1'b0;
      frame_err <= 1'b0;
      case (state_reg)
        RMII_RX_IDLE: begin
          if (c1) begin
            state_reg   <= RMII_RX_PRE;
            pre_cnt_reg <= (d1 == RMII_PRE_DIBIT) ? PRE_W'(1) : '0;
          end
        end
        RMII_RX_PRE: begin
          if (!c1) begin
            state_reg <= RMII_RX_DROP;
          end else if (d1 == RMII_PRE_DIBIT) begin
            if (pre_cnt_reg != PRE_W'(MIN_PREAMBLE_DIBITS))
              pre_cnt_reg <= pre_cnt_reg + 1'b1;
          end else if (d1 == RMII_IDLE_DIBIT && pre_cnt_reg == '0) begin
            state_reg <= RMII_RX_PRE;
          end else if (d1 == RMII_SFD_DIBIT && pre_cnt_reg >= PRE_W'(MIN_PREAMBLE_DIBITS)) begin
            state_reg   <= RMII_RX_DATA;
            dib_cnt_reg <= '0;
            p_val_reg   <= 1'b0;
            low_reg     <= 1'b0;
          end else begin
            state_reg <= RMII_RX_DROP;
          end
        end
        RMII_RX_DATA: begin
          if (dib_cnt_reg == CNT_W'(MAX_FRAME_DIBITS)) begin
            // Truncation is reported one cycle after the final emitted dibit.
            done_out  <= 1'b1;
            frame_err <= 1'b1;
            p_val_reg <= 1'b0;
            state_reg <= RMII_RX_DROP;
          end else if (!c1 && low_reg) begin
            // Second low cycle: the dibit held from the first low cycle was idle, not data.
            done_out  <= 1'b1;
            frame_err <= dibits_misaligned(dib_cnt_reg[1:0]);
            p_val_reg <= 1'b0;
            state_reg <= RMII_RX_IDLE;
          end else begin
            // A single low cycle may be an end-of-frame toggle, so its dibit is held, not dropped.
            if (p_val_reg) begin
              out         <= p_dib_reg;
              outclk      <= 1'b1;
              dib_cnt_reg <= dib_cnt_reg + 1'b1;
            end
            p_dib_reg <= d1;
            p_val_reg <= 1'b1;
            low_reg   <= !c1;
          end
        end
        default: begin
          if (!c1) state_reg <= RMII_RX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rmii_rx_framer.sv
// Directed bench for rmii_rx_framer: drives RMII frames and checks the emitted
// dibit stream, done_out/frame_err and reset behaviour.
module tb_rmii_rx_framer;

  logic       clk = 1'b0;
  logic       reset;
  logic       crs_dv;
  logic [1:0] rxd;
  logic [1:0] out;
  logic       outclk;
  logic       done_out;
  logic       frame_err;

  int checks = 0;
  int errors = 0;

  int         cyc = 0;
  int         mon_cnt = 0;
  int         done_cnt = 0;
  int         overlap = 0;
  int         done_cyc = 0;
  int         last_out_cyc = 0;
  logic       last_err = 1'b0;
  logic [1:0] mon_dib [0:16383];
  logic [7:0] exp_bytes [0:2047];

  rmii_rx_framer dut (
    .clk       (clk),
    .reset     (reset),
    .crs_dv    (crs_dv),
    .rxd       (rxd),
    .out       (out),
    .outclk    (outclk),
    .done_out  (done_out),
    .frame_err (frame_err)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (outclk) begin
      mon_dib[mon_cnt] <= out;
      mon_cnt          <= mon_cnt + 1;
      last_out_cyc     <= cyc + 1;
    end
    if (done_out) begin
      done_cnt <= done_cnt + 1;
      last_err <= frame_err;
      done_cyc <= cyc + 1;
      if (outclk) overlap <= overlap + 1;
    end
  end

  task automatic send(input logic c, input logic [1:0] d);
    crs_dv = c;
    rxd    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 2'b00);
  endtask

  task automatic preamble();
    send(1'b1, 2'b00);
    send(1'b1, 2'b00);
    for (int i = 0; i < 28; i++) send(1'b1, 2'b01);
    send(1'b1, 2'b11);
  endtask

  task automatic body(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = exp_bytes[i / 4] >> (2 * (i % 4));
      send(1'b1, b[1:0]);
    end
  endtask

  task automatic end_frame(output int low2_cyc);
    send(1'b0, 2'b10);
    low2_cyc = cyc;
    send(1'b0, 2'b01);
  endtask

  task automatic test_reset();
    reset = 1'b1; crs_dv = 1'b0; rxd = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out !== 2'b00) begin errors++; $display("FAIL reset_out got %0d want 0", out); end
    checks++; if (outclk !== 1'b0) begin errors++; $display("FAIL reset_outclk got %0b want 0", outclk); end
    checks++; if (done_out !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done_out); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", frame_err); end
    reset = 1'b0;
    idle(4);
  endtask

  task automatic test_clean_frame();
    int b_cnt, b_done, b_ov, low2;
    logic [7:0] got;
    b_cnt = mon_cnt; b_done = done_cnt; b_ov = overlap;
    for (int i = 0; i < 64; i++) exp_bytes[i] = 8'(i);
    preamble();
    body(256);
    end_frame(low2);
    idle(6);
    checks++; if (mon_cnt - b_cnt != 256) begin errors++; $display("FAIL clean_count got %0d want 256", mon_cnt - b_cnt); end
    for (int k = 0; k < 64; k++) begin
      got = {mon_dib[b_cnt+4*k+3], mon_dib[b_cnt+4*k+2], mon_dib[b_cnt+4*k+1], mon_dib[b_cnt+4*k]};
      checks++; if (got !== exp_bytes[k]) begin errors++; $display("FAIL clean_byte%0d got %02h want %02h", k, got, exp_bytes[k]); end
    end
    checks++; if (done_cnt - b_done != 1) begin errors++; $display("FAIL clean_done got %0d want 1", done_cnt - b_done); end
    checks++; if (last_err !== 1'b0) begin errors++; $display("FAIL clean_err got %0b want 0", last_err); end
    checks++; if (done_cyc - low2 != 3) begin errors++; $display("FAIL clean_done_lat got %0d want 3", done_cyc - low2); end
    checks++; if (!(done_cyc > last_out_cyc) || overlap != b_ov) begin
      errors++; $display("FAIL clean_done_after_out got done %0d last_out %0d want done later", done_cyc, last_out_cyc);
    end
  endtask

  task automatic test_toggle();
    int b_cnt, b_done, low2;
    logic [7:0] b, got;
    logic [15:0] crs_pat;
    b_cnt = mon_cnt; b_done = done_cnt;
    exp_bytes[0] = 8'hC6; exp_bytes[1] = 8'h1B; exp_bytes[2] = 8'h72; exp_bytes[3] = 8'hE4;
    crs_pat = 16'b1010_1111_1111_1111;
    preamble();
    for (int i = 0; i < 16; i++) begin
      b = exp_bytes[i / 4] >> (2 * (i % 4));
      send(crs_pat[i], b[1:0]);
    end
    end_frame(low2);
    idle(6);
    checks++; if (mon_cnt - b_cnt != 16) begin errors++; $display("FAIL toggle_count got %0d want 16", mon_cnt - b_cnt); end
    for (int k = 0; k < 4; k++) begin
      got = {mon_dib[b_cnt+4*k+3], mon_dib[b_cnt+4*k+2], mon_dib[b_cnt+4*k+1], mon_dib[b_cnt+4*k]};
      checks++; if (got !== exp_bytes[k]) begin errors++; $display("FAIL toggle_byte%0d got %02h want %02h", k, got, exp_bytes[k]); end
    end
    checks++; if (done_cnt - b_done != 1) begin errors++; $display("FAIL toggle_done got %0d want 1", done_cnt - b_done); end
    checks++; if (last_err !== 1'b0) begin errors++; $display("FAIL toggle_err got %0b want 0", last_err); end
  endtask

  task automatic test_short_preamble();
    int b_cnt, b_done, low2;
    logic [7:0] got;
    b_cnt = mon_cnt; b_done = done_cnt;
    for (int i = 0; i < 4; i++) send(1'b1, 2'b01);
    send(1'b1, 2'b11);
    for (int i = 0; i < 8; i++) send(1'b1, 2'b10);
    end_frame(low2);
    checks++; if (mon_cnt != b_cnt) begin errors++; $display("FAIL short_outclk got %0d want 0", mon_cnt - b_cnt); end
    checks++; if (done_cnt != b_done) begin errors++; $display("FAIL short_done got %0d want 0", done_cnt - b_done); end
    for (int i = 0; i < 8; i++) exp_bytes[i] = 8'(8'h11 * i);
    preamble();
    body(32);
    end_frame(low2);
    idle(6);
    checks++; if (mon_cnt - b_cnt != 32) begin errors++; $display("FAIL short_next_count got %0d want 32", mon_cnt - b_cnt); end
    for (int k = 0; k < 8; k++) begin
      got = {mon_dib[b_cnt+4*k+3], mon_dib[b_cnt+4*k+2], mon_dib[b_cnt+4*k+1], mon_dib[b_cnt+4*k]};
      checks++; if (got !== exp_bytes[k]) begin errors++; $display("FAIL short_next_byte%0d got %02h want %02h", k, got, exp_bytes[k]); end
    end
    checks++; if (done_cnt - b_done != 1 || last_err !== 1'b0) begin
      errors++; $display("FAIL short_next_done got %0d err %0b want 1 err 0", done_cnt - b_done, last_err);
    end
  endtask

  task automatic test_bad_preamble();
    int b_cnt, b_done, low2;
    b_cnt = mon_cnt; b_done = done_cnt;
    for (int i = 0; i < 10; i++) send(1'b1, 2'b01);
    send(1'b1, 2'b10);
    send(1'b1, 2'b11);
    for (int i = 0; i < 16; i++) send(1'b1, 2'(i));
    end_frame(low2);
    idle(4);
    checks++; if (mon_cnt != b_cnt) begin errors++; $display("FAIL bad_pre_outclk got %0d want 0", mon_cnt - b_cnt); end
    checks++; if (done_cnt != b_done) begin errors++; $display("FAIL bad_pre_done got %0d want 0", done_cnt - b_done); end
  endtask

  task automatic test_misaligned();
    int b_cnt, b_done, low2;
    b_cnt = mon_cnt; b_done = done_cnt;
    for (int i = 0; i < 72; i++) exp_bytes[i] = 8'(i + 5);
    preamble();
    body(257);
    end_frame(low2);
    idle(6);
    checks++; if (mon_cnt - b_cnt != 257) begin errors++; $display("FAIL misaligned_count got %0d want 257", mon_cnt - b_cnt); end
    checks++; if (done_cnt - b_done != 1) begin errors++; $display("FAIL misaligned_done got %0d want 1", done_cnt - b_done); end
    checks++; if (last_err !== 1'b1) begin errors++; $display("FAIL misaligned_err got %0b want 1", last_err); end
  endtask

  task automatic test_oversize();
    int b_cnt, b_done, b_ov, low2;
    b_cnt = mon_cnt; b_done = done_cnt; b_ov = overlap;
    for (int i = 0; i < 1526; i++) exp_bytes[i] = 8'(i);
    preamble();
    body(6100);
    end_frame(low2);
    idle(6);
    checks++; if (mon_cnt - b_cnt != 6088) begin errors++; $display("FAIL oversize_count got %0d want 6088", mon_cnt - b_cnt); end
    checks++; if (done_cnt - b_done != 1) begin errors++; $display("FAIL oversize_done got %0d want 1", done_cnt - b_done); end
    checks++; if (last_err !== 1'b1) begin errors++; $display("FAIL oversize_err got %0b want 1", last_err); end
    checks++; if (overlap != b_ov) begin errors++; $display("FAIL oversize_overlap got %0d want 0", overlap - b_ov); end
  endtask

  task automatic test_back_to_back();
    int b_cnt, b_done, low2;
    logic [7:0] got;
    b_cnt = mon_cnt; b_done = done_cnt;
    exp_bytes[0] = 8'h5A; exp_bytes[1] = 8'hA5; exp_bytes[2] = 8'h3C; exp_bytes[3] = 8'h96;
    preamble(); body(16); end_frame(low2);
    preamble(); body(16); end_frame(low2);
    idle(6);
    checks++; if (mon_cnt - b_cnt != 32) begin errors++; $display("FAIL b2b_count got %0d want 32", mon_cnt - b_cnt); end
    for (int k = 0; k < 8; k++) begin
      got = {mon_dib[b_cnt+4*k+3], mon_dib[b_cnt+4*k+2], mon_dib[b_cnt+4*k+1], mon_dib[b_cnt+4*k]};
      checks++; if (got !== exp_bytes[k % 4]) begin errors++; $display("FAIL b2b_byte%0d got %02h want %02h", k, got, exp_bytes[k % 4]); end
    end
    checks++; if (done_cnt - b_done != 2) begin errors++; $display("FAIL b2b_done got %0d want 2", done_cnt - b_done); end
  endtask

  task automatic test_reset_mid();
    int b_cnt, b_done;
    b_cnt = mon_cnt; b_done = done_cnt;
    for (int i = 0; i < 16; i++) exp_bytes[i] = 8'hFF - 8'(i);
    preamble();
    body(40);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (mon_cnt - b_cnt != 38) begin errors++; $display("FAIL mid_pre_count got %0d want 38", mon_cnt - b_cnt); end
    checks++; if (outclk !== 1'b0 || out !== 2'b00) begin errors++; $display("FAIL mid_reset_out got outclk %0b out %0d want 0 0", outclk, out); end
    checks++; if (done_out !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL mid_reset_done got %0b err %0b want 0 0", done_out, frame_err);
    end
    send(1'b1, 2'b10);
    reset = 1'b0;
    idle(8);
    checks++; if (done_cnt != b_done) begin errors++; $display("FAIL mid_no_done got %0d want 0", done_cnt - b_done); end
    checks++; if (mon_cnt - b_cnt != 38) begin errors++; $display("FAIL mid_post_count got %0d want 38", mon_cnt - b_cnt); end
  endtask

  initial begin
    reset = 1'b1; crs_dv = 1'b0; rxd = 2'b00;
    test_reset();
    test_clean_frame();
    test_toggle();
    test_short_preamble();
    test_bad_preamble();
    test_misaligned();
    test_oversize();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
